// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
//   Decodes command bytes from a UART receiver and bridges them onto a simple
//   register file: multi-byte writes (optionally acknowledged), single-word
//   reads and a full-memory DUMP streamed back through the UART transmitter.
//
//   State | meaning
//   ------+-------------------------------------------------------------
//   IDLE    | waiting for a command byte
//   RX_WORD | collecting NB write data bytes, MSB first, with timeout
//   WRITE   | one-cycle write strobe of the assembled word
//   RD_ADDR | read address on r_addr_o, memory access in flight
//   RD_LAT  | capture r_data_i into the TX shift register
//   TX_LOAD | wait for TX idle, then launch the current MSB byte
//   TX_HOLD | let the transmitter raise its busy flag
//   TX_WAIT | wait for TX idle, then shift or finish the word
//   ACK     | load the write acknowledge byte
//
// Ports
//   clk_in, reset        clock, asynchronous active-low reset
//   rx_rdy_i, rx_data_i  UART RX level-ready and byte
//   ser_busy_i           UART TX busy
//   ser_enable_o/data_o  one-cycle TX start strobe and byte
//   we_o, w_addr_o, w_data_o   register-file write port
//   r_addr_o, r_data_i         register-file read port (1-cycle latency)
//   busy_o               high whenever not in IDLE
//   err_o                one-cycle pulse on any protocol error
module uart_reg_bridge #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 1000000,
    parameter int ACK_EN  = 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              rx_rdy_i,
    input  logic [7:0]        rx_data_i,
    input  logic              ser_busy_i,
    output logic              ser_enable_o,
    output logic [7:0]        ser_data_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [DATA_W-1:0] w_data_o,
    output logic [ADDR_W-1:0] r_addr_o,
    input  logic [DATA_W-1:0] r_data_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RX_WORD, S_WRITE, S_RD_ADDR, S_RD_LAT,
        S_TX_LOAD, S_TX_HOLD, S_TX_WAIT, S_ACK
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rx_rdy;
    logic [DATA_W-1:0]   r_shadow;
    logic [DATA_W-1:0]   r_tx_sr;
    logic [2:0]          r_byte_cnt;
    logic [2:0]          r_tx_left;
    logic [TW-1:0]       r_tmo;
    logic                r_dump;
    logic                r_ser_en;
    logic [7:0]          r_ser_data;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [ADDR_W-1:0]   r_raddr;
    logic                r_err;

    logic                w_accept;
    logic                w_cmd_acc;
    logic                w_addr_ok;
    logic                w_cmd_wr;
    logic                w_cmd_rd;
    logic                w_cmd_dump;
    logic                w_cmd_bad;
    logic                w_last_byte;
    logic                w_tmo_hit;
    logic                w_tx_last;
    logic                w_dump_more;
    logic                w_stray;
    logic [7:0]          w_one_byte;
    logic [DATA_W-1:0]   w_one_word;

    assign w_accept    = rx_rdy_i & ~r_rx_rdy;
    assign w_cmd_acc   = w_accept && (r_state == S_IDLE);
    assign w_addr_ok   = ({1'b0, rx_data_i[3:0]} < 5'(DEPTH));
    assign w_cmd_wr    = w_cmd_acc && w_addr_ok && (rx_data_i[7:4] == 4'h6);
    assign w_cmd_rd    = w_cmd_acc && w_addr_ok && (rx_data_i[7:4] == 4'h7);
    assign w_cmd_dump  = w_cmd_acc && w_addr_ok && (rx_data_i[7:4] == 4'h8);
    assign w_cmd_bad   = w_cmd_acc && !(w_cmd_wr || w_cmd_rd || w_cmd_dump);
    assign w_last_byte = (r_byte_cnt == 3'(NB - 1));
    // r_tmo counts clock edges since the last accepted byte, the accept
    // edge included, so the error lands exactly TIMEOUT cycles later.
    assign w_tmo_hit   = (TIMEOUT != 0) && !w_accept &&
                         (32'(r_tmo) >= 32'(TIMEOUT - 1));
    assign w_tx_last   = (r_tx_left == 3'd1);
    assign w_dump_more = r_dump && (r_raddr != ADDR_W'(DEPTH - 1));
    assign w_stray     = w_accept && (r_state != S_IDLE) && (r_state != S_RX_WORD);
    // Single-byte responses ride the word shifter, parked in the MSB slot.
    assign w_one_byte  = (r_state == S_ACK) ? {4'hA, 4'(r_waddr)} : 8'hEE;
    assign w_one_word  = DATA_W'(w_one_byte) << (DATA_W - 8);

    assign ser_enable_o = r_ser_en;
    assign ser_data_o   = r_ser_data;
    assign we_o         = r_we;
    assign w_addr_o     = r_waddr;
    assign w_data_o     = r_wdata;
    assign r_addr_o     = r_raddr;
    assign busy_o       = (r_state != S_IDLE);
    assign err_o        = r_err;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_wr)                       w_state_nxt = S_RX_WORD;
                else if (w_cmd_rd || w_cmd_dump)    w_state_nxt = S_RD_ADDR;
                else if (w_cmd_bad && ACK_EN != 0)  w_state_nxt = S_TX_LOAD;
            end
            S_RX_WORD: begin
                if (w_accept && w_last_byte) w_state_nxt = S_WRITE;
                else if (w_tmo_hit)          w_state_nxt = S_IDLE;
            end
            S_WRITE:   w_state_nxt = (ACK_EN != 0) ? S_ACK : S_IDLE;
            S_RD_ADDR: w_state_nxt = S_RD_LAT;
            S_RD_LAT:  w_state_nxt = S_TX_LOAD;
            S_TX_LOAD: if (!ser_busy_i) w_state_nxt = S_TX_HOLD;
            S_TX_HOLD: w_state_nxt = S_TX_WAIT;
            S_TX_WAIT: begin
                if (!ser_busy_i) begin
                    if (!w_tx_last)       w_state_nxt = S_TX_LOAD;
                    else if (w_dump_more) w_state_nxt = S_RD_ADDR;
                    else                  w_state_nxt = S_IDLE;
                end
            end
            S_ACK:     w_state_nxt = S_TX_LOAD;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_rx_rdy   <= 1'b0;
            r_shadow   <= '0;
            r_tx_sr    <= '0;
            r_byte_cnt <= '0;
            r_tx_left  <= '0;
            r_tmo      <= '0;
            r_dump     <= 1'b0;
            r_ser_en   <= 1'b0;
            r_ser_data <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_raddr    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rx_rdy <= rx_rdy_i;
            r_we     <= 1'b0;
            r_ser_en <= 1'b0;
            r_err    <= w_stray || w_cmd_bad || ((r_state == S_RX_WORD) && w_tmo_hit);
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_wr) begin
                        r_waddr    <= rx_data_i[ADDR_W-1:0];
                        r_byte_cnt <= '0;
                        r_tmo      <= '0;
                        r_dump     <= 1'b0;
                    end else if (w_cmd_rd) begin
                        r_raddr <= rx_data_i[ADDR_W-1:0];
                        r_dump  <= 1'b0;
                    end else if (w_cmd_dump) begin
                        r_raddr <= '0;
                        r_dump  <= 1'b1;
                    end else if (w_cmd_bad) begin
                        r_tx_sr   <= w_one_word;
                        r_tx_left <= 3'd1;
                        r_dump    <= 1'b0;
                    end
                end
                S_RX_WORD: begin
                    if (w_accept) begin
                        r_shadow   <= (r_shadow << 8) | DATA_W'(rx_data_i);
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        r_tmo      <= TW'(1);
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_WRITE: begin
                    r_wdata <= r_shadow;
                    r_we    <= 1'b1;
                end
                S_RD_LAT: begin
                    r_tx_sr   <= r_data_i;
                    r_tx_left <= 3'(NB);
                end
                S_TX_LOAD: begin
                    if (!ser_busy_i) begin
                        r_ser_data <= r_tx_sr[DATA_W-1 -: 8];
                        r_ser_en   <= 1'b1;
                    end
                end
                S_TX_WAIT: begin
                    if (!ser_busy_i) begin
                        if (!w_tx_last) begin
                            r_tx_sr   <= r_tx_sr << 8;
                            r_tx_left <= r_tx_left - 3'd1;
                        end else if (w_dump_more) begin
                            r_raddr <= r_raddr + ADDR_W'(1);
                        end
                    end
                end
                S_ACK: begin
                    r_tx_sr   <= w_one_word;
                    r_tx_left <= 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Parametrised UART-to-register-file bridge, successor to the fixed 16-bit, 4-bit-address controller. It decodes command bytes from the UART receiver, assembles multi-byte write words, and performs single or burst reads back over the UART transmitter. Writes are optionally acknowledged, and stalled partial writes time out. It sits between the UART RX/TX pair and the PID coefficient/register memory.

## Interface
- DATA_W, 16: word width; multiple of 8, range 8..32; NB = DATA_W/8 bytes per word
- ADDR_W, 4: register address width, 1..4; DEPTH = 2^ADDR_W
- TIMEOUT, 1000000: clk_in cycles allowed between bytes of a write; 0 disables the timeout
- ACK_EN, 1: 1 enables ack/error response bytes

Ports:
- clk_in  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- rx_rdy_i  in  1  UART RX data-ready (level); its rising edge marks a new byte
- rx_data_i  in  8  UART RX byte, stable while rx_rdy_i is high
- ser_busy_i  in  1  UART TX busy; the transmitter raises it the cycle after ser_enable_o
- ser_enable_o  out  1  one-cycle TX start strobe
- ser_data_o  out  8  TX byte, valid while ser_enable_o is high
- we_o  out  1  one-cycle write strobe
- w_addr_o  out  ADDR_W  write address
- w_data_o  out  DATA_W  write data
- r_addr_o  out  ADDR_W  read address
- r_data_i  in  DATA_W  read data, valid 1 cycle after r_addr_o changes
- busy_o  out  1  high whenever the FSM is not in IDLE
- err_o  out  1  one-cycle pulse on any protocol error

## Operation
- Byte accept: rx_rdy_i is registered; a byte is accepted on cycles where rx_rdy_i=1 and the registered value is 0. rx_data_i is sampled in that cycle.
- Command byte, accepted only in IDLE: upper nibble is the opcode, lower nibble the address.
  - 0x6 WRITE
  - 0x7 READ
  - 0x8 DUMP (read all addresses 0..DEPTH-1)
- Command validity:
  - Address ≥ DEPTH: command rejected.
  - Other opcodes in IDLE: rejected.
  - On rejection: err_o pulses and, if ACK_EN=1, error byte 0xEE is sent.
- States: IDLE, RX_WORD, WRITE, RD_ADDR, RD_LAT, TX_LOAD, TX_HOLD, TX_WAIT, ACK.
- WRITE path:
  - IDLE→RX_WORD: latch w_addr_o, clear byte counter and timeout counter.
  - RX_WORD: each accepted byte shifts into the shadow word, MSB first. After NB bytes, go to WRITE.
  - WRITE: load w_data_o, we_o=1 for exactly one cycle.
  - WRITE→ACK if ACK_EN=1 (ack byte 0xA0|addr), else →IDLE.
- READ path:
  - IDLE→RD_ADDR: drive r_addr_o.
  - RD_ADDR→RD_LAT: one cycle.
  - RD_LAT: capture r_data_i into the TX shift register.
  - TX_LOAD: waits for ser_busy_i=0, then drives ser_data_o with the MSB byte and ser_enable_o=1 for one cycle.
  - TX_HOLD: unconditional one-cycle hold.
  - TX_WAIT: waits for ser_busy_i=0, then shifts and returns to TX_LOAD until NB bytes are sent.
- DUMP: same as READ starting at address 0. After NB bytes, r_addr_o increments and the FSM returns to RD_ADDR until address DEPTH-1 completes, then →IDLE.
- ACK and error bytes use the same TX_LOAD/TX_HOLD/TX_WAIT handshake with a one-byte count.
- Timeout: in RX_WORD, the counter increments every cycle and clears on each accepted byte. When it reaches TIMEOUT:
  - →IDLE, err_o pulses, no write occurs.
  - No error byte is sent, so a stray data byte cannot desynchronise the stream.
- A byte accepted in any state other than IDLE/RX_WORD is discarded and err_o pulses; the FSM is unaffected.
- Exactly NB (READ) or NB·DEPTH (DUMP) strobes per command; never an extra byte.

## Timing
- Reset (asynchronous assert, synchronous release to IDLE): all outputs 0, counters 0, shadow registers 0.
- Write latency: we_o asserts 2 cycles after the accept cycle of the last data byte (accept→WRITE entry→strobe).
- Read latency: first ser_enable_o occurs 4 cycles after the command accept cycle when ser_busy_i=0.
- Minimum spacing of ser_enable_o pulses: 3 cycles, and always gated by ser_busy_i=0.
- A reset asserted mid-write or mid-transfer aborts with no we_o and no further ser_enable_o.
- Accept and timeout in the same cycle: the accept wins and the counter clears.
- r_addr_o wraps nowhere; DUMP stops at DEPTH-1.

## Test plan
- WRITE, DATA_W=16: bytes 0x63, 0x12, 0x34 → one we_o with w_addr_o=3, w_data_o=0x1234; then ser byte 0xA3.
- READ after WRITE: 0x73 with r_data_i=0x1234, TX busy 10 cycles per byte → exactly two strobes, 0x12 then 0x34; busy_o low afterwards.
- DATA_W=32, ADDR_W=2, DUMP 0x80 → 16 bytes in order addr0..3, MSB first; r_addr_o ends at 3.
- TIMEOUT=50: 0x65, 0xAB, then silence → err_o at cycle 50 after 0xAB; no we_o; next 0x65, 0x01, 0x02 writes 0x0102.
- ADDR_W=2: 0x74 and 0x9F → err_o each and byte 0xEE each; with ACK_EN=0 → err_o only, no TX.
- Reset asserted after 0x61, 0xFF → outputs 0 immediately; after release, a write completes normally.
